// File: rtl/exec_stage.sv
// Multi-cycle execute stage: read A, read B, ALU with B shifter, write back.
// Optional N/V status flags are built only with EXEC_STAGE_STATUS_NV_EN defined.
module exec_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [2:0]    rn_a,
    input  logic [2:0]    rn_b,
    input  logic [2:0]    rd,
    input  logic [1:0]    alu_op,
    input  logic [1:0]    shift,
    output logic [2:0]    readnum,
    input  logic [DW-1:0] rf_data,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [DW-1:0] data_in,
    output logic          busy,
    output logic          done,
    output logic          status_z,
    output logic          status_n,
    output logic          status_v
);

    typedef enum logic [2:0] {
        IDLE, RDA, RDB, EXEC, WB
    } state_t;

    state_t        state;
    logic [2:0]    fa, fb, frd;
    logic [1:0]    fop, fsh;
    logic [DW-1:0] a_q, b_q, c_q;
    logic [DW-1:0] sb, res;
    logic          z_q;

    // Shift operand B, then run the selected ALU operation on A and shifted B
    always_comb begin
        sb = b_q;
        unique case (fsh)
            2'b00: sb = b_q;
            2'b01: sb = {b_q[DW-2:0], 1'b0};
            2'b10: sb = {1'b0, b_q[DW-1:1]};
            2'b11: sb = {b_q[DW-1], b_q[DW-1:1]};
        endcase
        res = '0;
        unique case (fop)
            2'b00: res = a_q + sb;
            2'b01: res = a_q + ~sb + {{(DW-1){1'b0}}, 1'b1};
            2'b10: res = a_q & sb;
            2'b11: res = ~sb;
        endcase
    end

    // Sequencer: capture fields on accept, read A, read B, execute, write back
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            fa    <= '0;
            fb    <= '0;
            frd   <= '0;
            fop   <= '0;
            fsh   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            z_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, WB: begin
                    if (start) begin
                        fa    <= rn_a;
                        fb    <= rn_b;
                        frd   <= rd;
                        fop   <= alu_op;
                        fsh   <= shift;
                        state <= RDA;
                    end else begin
                        state <= IDLE;
                    end
                end
                RDA: begin
                    a_q   <= rf_data;
                    state <= RDB;
                end
                RDB: begin
                    b_q   <= rf_data;
                    state <= EXEC;
                end
                EXEC: begin
                    c_q   <= res;
                    z_q   <= (res == '0);
                    state <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXEC_STAGE_STATUS_NV_EN
    logic n_q, v_q;
    logic ovf;

    // Signed overflow: operands agree in sign (after B inversion for SUB) but result differs
    always_comb begin
        ovf = 1'b0;
        unique case (fop)
            2'b00: ovf = (a_q[DW-1] == sb[DW-1]) && (res[DW-1] != a_q[DW-1]);
            2'b01: ovf = (a_q[DW-1] != sb[DW-1]) && (res[DW-1] != a_q[DW-1]);
            default: ovf = 1'b0;
        endcase
    end

    // Negative and overflow flags change only in EXEC
    always_ff @(posedge clk) begin
        if (!resetn) begin
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state == EXEC) begin
            n_q <= res[DW-1];
            v_q <= ovf;
        end
    end

    assign status_n = n_q;
    assign status_v = v_q;
`else
    assign status_n = 1'b0;
    assign status_v = 1'b0;
`endif

    assign status_z = z_q;
    assign busy     = (state != IDLE);
    assign done     = (state == WB);
    assign write    = (state == WB) & resetn;
    assign readnum  = (state == RDA) ? fa :
                      (state == RDB) ? fb : 3'd0;
    assign writenum = (state == WB) ? frd : 3'd0;
    assign data_in  = (state == WB) ? c_q : '0;

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter: DW, default 16, the datapath and register file word width.
REQ-002 Port: clk, input, 1, rising-edge clock; all state updates on posedge clk.
REQ-003 Port: resetn, input, 1, reset; one clock, reset synchronous, active-low.
REQ-004 Port: start, input, 1, operation request, sampled on posedge clk.
REQ-005 Port: rn_a, input, 3, register number of source operand A.
REQ-006 Port: rn_b, input, 3, register number of source operand B.
REQ-007 Port: rd, input, 3, destination register number.
REQ-008 Port: alu_op, input, 2, operation select: 00 ADD, 01 SUB, 10 AND, 11 NOT B.
REQ-009 Port: shift, input, 2, B shift select: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
REQ-010 Port: readnum, output, 3, read select driven to the register file.
REQ-011 Port: rf_data, input, DW, register file read data, combinational from readnum.
REQ-012 Port: writenum, output, 3, write select to the register file.
REQ-013 Port: write, output, 1, register file write enable.
REQ-014 Port: data_in, output, DW, register file write data.
REQ-015 Port: busy, output, 1, high whenever state is not IDLE.
REQ-016 Port: done, output, 1, one-cycle pulse during WB.
REQ-017 Port: status_z/status_n/status_v, output, 1 each, registered zero, negative and overflow flags.

Function
REQ-018 FSM states SHALL be IDLE, RDA, RDB, EXEC and WB, with exactly one state active per cycle.
- IDLE: start=1 -> RDA, capturing rn_a, rn_b, rd, alu_op and shift into internal registers; start=0 -> stay in IDLE.
- RDA: readnum=rn_a (captured); A<=rf_data; -> RDB.
- RDB: readnum=rn_b (captured); B<=rf_data; -> EXEC.
- EXEC: C<=ALU(A, shift(B)); flags updated; -> WB.
- WB: write=1, writenum=rd, data_in=C, done=1; start=1 -> RDA with new fields captured; start=0 -> IDLE.
REQ-019 start SHALL be ignored in RDA, RDB and EXEC; operand fields SHALL be read only when start is accepted.
REQ-020 Latency SHALL be fixed: accept edge at t, done high in cycle t+4, regfile written at the end of that cycle; back-to-back throughput is one operation per 4 cycles.
REQ-021 readnum SHALL be 0 outside RDA and RDB; writenum and data_in SHALL be 0 outside WB.
REQ-022 Shift rules: LSL1 shifts in 0 at bit 0; LSR1 shifts in 0 at the MSB; ASR1 replicates the MSB.
REQ-023 ADD and SUB SHALL wrap modulo 2^DW (A-B computed as A+~B+1); AND is bitwise; NOT B is ~shift(B).
REQ-024 status_z SHALL equal (C_next==0), and the flags SHALL be updated only in EXEC.
REQ-025 An operation with rd equal to the next operation's rn_a or rn_b SHALL read the new value, because the WB write completes before the next RDA.
REQ-026 write SHALL be (state==WB) & resetn, so that no write occurs in a cycle where resetn is low.

Reset
REQ-027 resetn=0 at a posedge SHALL force IDLE and clear A, B, C, the captured fields and all flags to 0.
REQ-028 Reset mid-operation SHALL abort the operation with no register file write; start is ignored while resetn=0.
REQ-029 After reset, busy, done, write, readnum, writenum, data_in and all status outputs SHALL read 0.

Configuration
REQ-030 With macro EXEC_STAGE_STATUS_NV_EN defined, status_n SHALL be C_next[DW-1], and status_v SHALL be signed overflow for ADD/SUB (0 for AND/NOT).
REQ-031 Without EXEC_STAGE_STATUS_NV_EN, status_n and status_v SHALL be constant 0 and their registers SHALL be omitted; status_z is unaffected.

Verification
REQ-032 R1=5, R2=3; start with rn_a=1, rn_b=2, rd=3, ADD, no shift -> done in the 4th cycle after accept; R3=8; Z=0.
REQ-033 R1=7, R2=7; SUB into R4 -> R4=0, Z=1, and V=0 when NV is enabled.
REQ-034 R1=0x7FFF, R2=1; ADD into R5 -> R5=0x8000; with NV: N=1, V=1; without NV: N=0, V=0.
REQ-035 R2=0x8002; NOT B with ASR1 into R6 -> R6=~0xC001=0x3FFE; LSR1 with AND and R1=0xFFFF -> 0x4001.
REQ-036 Back-to-back: second op (R3=R3+R3) with start held high in WB of the first -> it enters RDA with no IDLE cycle and reads the updated R3; a start pulse during RDB is ignored.
REQ-037 resetn=0 in the EXEC cycle -> no write occurs, the next state is IDLE, and all outputs are 0.
